evt2_source_arbiter: RTL and testbench
======================================

// Module: evt2_source_arbiter
// PURPOSE
//  Shares the single EVT 2.0 decoder input between two word sources: sensor FIFO (s0) and host replay/UART (s1).
//  The decoder holds one TIME_HIGH register, so the arbiter keeps a per-source TIME_HIGH shadow.
//  On a source switch it re-injects the new source's TIME_HIGH word so decoded timestamps never mix sources.
//  Sits between the input FIFOs and evt2_decoder's data_in/data_valid/data_ready.
// PARAMETERS
//  BURST_MAX  16  max words transferred per grant before re-arbitration (>=1)
// PORTS
//  clk           in   1   system clock
//  rst_n         in   1   synchronous reset, active low
//  cfg_mode      in   2   00 s0 only, 01 s1 only, 10 round-robin both, 11 disabled
//  s0_data       in   32  sensor EVT 2.0 word
//  s0_valid      in   1   s0 word available
//  s0_ready      out  1   s0 word consumed this cycle
//  s1_data       in   32  host EVT 2.0 word
//  s1_valid      in   1   s1 word available
//  s1_ready      out  1   s1 word consumed this cycle
//  m_data        out  32  word to decoder
//  m_valid       out  1   m_data valid
//  m_ready       in   1   decoder accepts (transfer = m_valid & m_ready)
//  active_src    out  1   source currently granted (0=s0, 1=s1)
//  grant_active  out  1   high in GRANT or INJECT
//  inject_count  out  16  number of injected TIME_HIGH words, saturates at 0xFFFF
// BEHAVIOUR
//  FSM: IDLE, INJECT, GRANT. All state is registered. rst_n=0 at a clock edge -> IDLE.
//  Reset values: m_valid=0, s0_ready=0, s1_ready=0, active_src=0, grant_active=0, inject_count=0.
//  Reset also sets: shadow th[0..1]=0, th_seen[0..1]=0, ctx=NONE, last_grant=1 (so s0 wins first tie), burst_cnt=0.
//  Reset mid-burst aborts the burst with no partial word. The upstream word is not consumed.
//  IDLE: m_valid=0, both s*_ready=0. Eligible sources: s0 if mode 00/10; s1 if mode 01/10; none if mode 11.
//   Winner = eligible source with valid=1. If both: the one != last_grant. None -> stay IDLE.
//   Winner w: active_src<=w, last_grant<=w, burst_cnt<=0.
//   Next state is INJECT if th_seen[w] && ctx!=w. Otherwise GRANT, with ctx<=w.
//  cfg_mode is sampled only in IDLE. A mode change takes effect at the next arbitration.
//  INJECT: m_data={4'h8, th[w]}, m_valid=1, s*_ready=0.
//   m_data is held stable while m_ready=0.
//   On transfer: ctx<=w, inject_count+=1 (saturating), -> GRANT.
//  GRANT (source w): m_data=sw_data, m_valid=sw_valid, sw_ready=m_ready&sw_valid; other source ready=0.
//   This is a combinational pass-through with 0 added latency. m_valid never depends on m_ready.
//   On a transfer whose word[31:28]==4'h8: th[w]<=word[27:0], th_seen[w]<=1.
//   Every transfer increments burst_cnt, including TIME_HIGH words.
//   -> IDLE when the transfer makes burst_cnt==BURST_MAX, or when sw_valid=0 in a cycle.
//   Between grants there is one IDLE bubble cycle, minimum.
//  Arbitration latency: source valid in IDLE at cycle N gives first m_valid at N+1 (GRANT or INJECT).
//  Words are never dropped, duplicated or reordered within a source. Only injected words are added.
//  Source with th_seen=0: no injection. ctx is set to it and the decoder keeps the stale TIME_HIGH.
//   This matches a sensor that has not yet sent TIME_HIGH.
//  Same source re-granted (ctx==w): no injection.
//  grant_active=1 in INJECT and GRANT.
// TESTING
//  Mode 00, s0 sends 0x1001_0802,0x0000_0000,0x1FFF_FFFF continuously
//   -> m_data equals each word in order, m_valid 1 cycle after s0_valid, inject_count=0.
//  Mode 10: s0 sends 0x8000_0123,0x1000_0010; s1 sends 0x8000_0456,0x0000_0020; then s0 sends 0x1000_0030
//   -> 0x8000_0123 is injected before 0x1000_0030, inject_count=1.
//  Mode 10, BURST_MAX=16, both valid continuously
//   -> alternating 16-word bursts starting with s0, exactly 1 idle cycle between bursts.
//  INJECT with m_ready held 0 for 3 cycles
//   -> m_data stays 0x8000_0123, m_valid=1, s0_ready=s1_ready=0; resumes on m_ready=1.
//  rst_n=0 for 1 cycle mid-burst, then s1 grant with no TIME_HIGH seen
//   -> all outputs reset values; no injection on grant.
//  Mode set to 11 during s0 burst
//   -> burst completes; afterwards m_valid=0 and s*_ready=0 while sources stay valid.

Source files
------------

// File: rtl/evt2_source_arbiter.sv
// Two-source arbiter in front of the EVT 2.0 decoder. It keeps a TIME_HIGH shadow for each
// source and re-injects it when the decoder's timestamp context changes to the other source.
module evt2_source_arbiter #(
  parameter int BURST_MAX = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  cfg_mode,
  input  logic [31:0] s0_data,
  input  logic        s0_valid,
  output logic        s0_ready,
  input  logic [31:0] s1_data,
  input  logic        s1_valid,
  output logic        s1_ready,
  output logic [31:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        active_src,
  output logic        grant_active,
  output logic [15:0] inject_count
);

  localparam int CW = $clog2(BURST_MAX + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_INJECT, ST_GRANT} state_e;

  state_e             state_q, state_d;
  logic               active_src_q, active_src_d;
  logic               last_grant_q, last_grant_d;
  logic [CW-1:0]      burst_cnt_q, burst_cnt_d;
  logic [1:0][27:0]   th_q, th_d;
  logic [1:0]         th_seen_q, th_seen_d;
  logic               ctx_valid_q, ctx_valid_d;
  logic               ctx_src_q, ctx_src_d;
  logic [15:0]        inject_count_q, inject_count_d;

  logic        elig0, elig1, req0, req1, win;
  logic [31:0] sel_data;
  logic        sel_valid;

  always_comb begin
    state_d        = state_q;
    active_src_d   = active_src_q;
    last_grant_d   = last_grant_q;
    burst_cnt_d    = burst_cnt_q;
    th_d           = th_q;
    th_seen_d      = th_seen_q;
    ctx_valid_d    = ctx_valid_q;
    ctx_src_d      = ctx_src_q;
    inject_count_d = inject_count_q;
    m_valid        = 1'b0;
    m_data         = 32'h0;
    s0_ready       = 1'b0;
    s1_ready       = 1'b0;
    win            = 1'b0;

    elig0     = (cfg_mode == 2'b00) || (cfg_mode == 2'b10);
    elig1     = (cfg_mode == 2'b01) || (cfg_mode == 2'b10);
    req0      = elig0 & s0_valid;
    req1      = elig1 & s1_valid;
    sel_data  = active_src_q ? s1_data : s0_data;
    sel_valid = active_src_q ? s1_valid : s0_valid;

    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          win          = (req0 && req1) ? ~last_grant_q : req1;
          active_src_d = win;
          last_grant_d = win;
          burst_cnt_d  = '0;
          if (th_seen_q[win] && !(ctx_valid_q && (ctx_src_q == win))) begin
            state_d = ST_INJECT;
          end else begin
            state_d     = ST_GRANT;
            ctx_valid_d = 1'b1;
            ctx_src_d   = win;
          end
        end
      end
      ST_INJECT: begin
        m_valid = 1'b1;
        m_data  = {4'h8, th_q[active_src_q]};
        if (m_ready) begin
          ctx_valid_d = 1'b1;
          ctx_src_d   = active_src_q;
          if (inject_count_q != 16'hFFFF) inject_count_d = inject_count_q + 16'd1;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        m_valid  = sel_valid;
        m_data   = sel_data;
        s0_ready = ~active_src_q & m_ready & s0_valid;
        s1_ready = active_src_q & m_ready & s1_valid;
        if (sel_valid && m_ready) begin
          if (sel_data[31:28] == 4'h8) begin
            th_d[active_src_q]      = sel_data[27:0];
            th_seen_d[active_src_q] = 1'b1;
          end
          burst_cnt_d = burst_cnt_q + 1'b1;
          if (burst_cnt_q == CW'(BURST_MAX - 1)) state_d = ST_IDLE;
        end else if (!sel_valid) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A reset cycle must not hand a word to the decoder or pop one from a source.
    if (!rst_n) begin
      m_valid  = 1'b0;
      s0_ready = 1'b0;
      s1_ready = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      active_src_q   <= 1'b0;
      last_grant_q   <= 1'b1;
      burst_cnt_q    <= '0;
      th_q           <= '0;
      th_seen_q      <= 2'b00;
      ctx_valid_q    <= 1'b0;
      ctx_src_q      <= 1'b0;
      inject_count_q <= 16'h0;
    end else begin
      state_q        <= state_d;
      active_src_q   <= active_src_d;
      last_grant_q   <= last_grant_d;
      burst_cnt_q    <= burst_cnt_d;
      th_q           <= th_d;
      th_seen_q      <= th_seen_d;
      ctx_valid_q    <= ctx_valid_d;
      ctx_src_q      <= ctx_src_d;
      inject_count_q <= inject_count_d;
    end
  end

  assign active_src   = active_src_q;
  assign grant_active = (state_q != ST_IDLE);
  assign inject_count = inject_count_q;

endmodule

// File: tb/tb_evt2_source_arbiter.sv
// Directed bench for evt2_source_arbiter: queue-fed sources, a per-cycle output log and
// hand-computed expected word orders and cycle positions.
module tb_evt2_source_arbiter;

  localparam int LOGN = 2048;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  cfg_mode;
  logic [31:0] s0_data, s1_data, m_data;
  logic        s0_valid, s1_valid, s0_ready, s1_ready;
  logic        m_valid, m_ready;
  logic        active_src, grant_active;
  logic [15:0] inject_count;

  evt2_source_arbiter #(.BURST_MAX(16)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_mode(cfg_mode),
    .s0_data(s0_data), .s0_valid(s0_valid), .s0_ready(s0_ready),
    .s1_data(s1_data), .s1_valid(s1_valid), .s1_ready(s1_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .active_src(active_src), .grant_active(grant_active), .inject_count(inject_count)
  );

  always #5 clk = ~clk;

  int          testCount = 0;
  int          failCount = 0;
  int          cycleNum = 0;
  logic [31:0] s0q[$];
  logic [31:0] s1q[$];
  logic [31:0] outLog[$];
  logic [31:0] mdLog[LOGN];
  bit          mvLog[LOGN], r0Log[LOGN], r1Log[LOGN], gaLog[LOGN], asLog[LOGN];

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] mode, input logic ready);
    cfg_mode = mode;
    m_ready  = ready;
  endtask

  task automatic waitOut(input int n, input int maxc);
    int c = 0;
    while (outLog.size() < n && c < maxc) begin
      @(negedge clk);
      c++;
    end
    checkOutput("drain_count", outLog.size(), n);
  endtask

  // Source model: present queue heads just after negedge, sample handshakes mid-low-phase.
  initial begin
    s0_valid = 1'b0; s1_valid = 1'b0; s0_data = '0; s1_data = '0;
    forever begin
      @(negedge clk);
      #1;
      cycleNum++;
      s0_valid = (s0q.size() > 0);
      s0_data  = s0_valid ? s0q[0] : 32'h0;
      s1_valid = (s1q.size() > 0);
      s1_data  = s1_valid ? s1q[0] : 32'h0;
      #2;
      if (cycleNum < LOGN) begin
        mvLog[cycleNum] = m_valid;
        mdLog[cycleNum] = m_data;
        r0Log[cycleNum] = s0_ready;
        r1Log[cycleNum] = s1_ready;
        gaLog[cycleNum] = grant_active;
        asLog[cycleNum] = active_src;
      end
      if (m_valid && m_ready) outLog.push_back(m_data);
      if (s0_ready && s0q.size() > 0) void'(s0q.pop_front());
      if (s1_ready && s1q.size() > 0) void'(s1q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int start, b;
    rst_n = 1'b0;
    applyStimulus(2'b00, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #2;
    checkOutput("rst_m_valid", m_valid, 0);
    checkOutput("rst_s0_ready", s0_ready, 0);
    checkOutput("rst_s1_ready", s1_ready, 0);
    checkOutput("rst_active_src", active_src, 0);
    checkOutput("rst_grant_active", grant_active, 0);
    checkOutput("rst_inject_count", inject_count, 0);

    // Mode 00: s0 only, s1 word must be ignored
    @(negedge clk);
    applyStimulus(2'b00, 1'b1);
    s0q.push_back(32'h1001_0802); s0q.push_back(32'h0000_0000); s0q.push_back(32'h1FFF_FFFF);
    s1q.push_back(32'h5555_AAAA);
    start = cycleNum + 1;
    waitOut(3, 20);
    repeat (2) @(negedge clk);
    checkOutput("m00_idle_cycle", mvLog[start], 0);
    checkOutput("m00_latency", mvLog[start+1], 1);
    checkOutput("m00_first_data", mdLog[start+1], 32'h1001_0802);
    checkOutput("m00_word0", outLog[0], 32'h1001_0802);
    checkOutput("m00_word1", outLog[1], 32'h0000_0000);
    checkOutput("m00_word2", outLog[2], 32'h1FFF_FFFF);
    checkOutput("m00_inject_count", inject_count, 0);
    checkOutput("m00_s1_untouched", s1q.size(), 1);
    s1q.delete();

    // Mode 10: TIME_HIGH re-injection for s0 after an s1 grant, with a stalled decoder
    applyStimulus(2'b10, 1'b1);
    b = outLog.size();
    s0q.push_back(32'h8000_0123); s0q.push_back(32'h1000_0010);
    waitOut(b + 2, 20);
    s1q.push_back(32'h8000_0456); s1q.push_back(32'h0000_0020);
    waitOut(b + 4, 20);
    repeat (2) @(negedge clk);
    applyStimulus(2'b10, 1'b0);
    s0q.push_back(32'h1000_0030);
    start = cycleNum + 1;
    repeat (4) @(negedge clk);
    applyStimulus(2'b10, 1'b1);
    waitOut(b + 6, 20);
    for (int k = 1; k <= 3; k++) begin
      checkOutput($sformatf("inj_hold_valid_%0d", k), mvLog[start+k], 1);
      checkOutput($sformatf("inj_hold_data_%0d", k), mdLog[start+k], 32'h8000_0123);
      checkOutput($sformatf("inj_hold_s0rdy_%0d", k), r0Log[start+k], 0);
      checkOutput($sformatf("inj_hold_s1rdy_%0d", k), r1Log[start+k], 0);
    end
    checkOutput("inj_grant_active", gaLog[start+1], 1);
    checkOutput("inj_seq0", outLog[b+0], 32'h8000_0123);
    checkOutput("inj_seq1", outLog[b+1], 32'h1000_0010);
    checkOutput("inj_seq2", outLog[b+2], 32'h8000_0456);
    checkOutput("inj_seq3", outLog[b+3], 32'h0000_0020);
    checkOutput("inj_seq4", outLog[b+4], 32'h8000_0123);
    checkOutput("inj_seq5", outLog[b+5], 32'h1000_0030);
    checkOutput("inj_count", inject_count, 1);

    // Reset mid-burst, then an s1 grant with no TIME_HIGH seen
    repeat (2) @(negedge clk);
    b = outLog.size();
    applyStimulus(2'b00, 1'b1);
    for (int i = 0; i < 10; i++) s0q.push_back(32'h2000_0000 + i);
    start = cycleNum + 1;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rstmid_not_consumed", s0q.size(), 7);
    checkOutput("rstmid_active_src", active_src, 0);
    checkOutput("rstmid_grant_active", grant_active, 0);
    checkOutput("rstmid_inject_count", inject_count, 0);
    rst_n = 1'b1;
    s0q.delete();
    applyStimulus(2'b01, 1'b1);
    s1q.push_back(32'h0000_0055);
    waitOut(b + 4, 20);
    repeat (2) @(negedge clk);
    checkOutput("rstmid_word0", outLog[b+0], 32'h2000_0000);
    checkOutput("rstmid_word2", outLog[b+2], 32'h2000_0002);
    checkOutput("rstmid_m_valid", mvLog[start+4], 0);
    checkOutput("rstmid_s0_ready", r0Log[start+4], 0);
    checkOutput("s1_no_inject_data", mdLog[start+6], 32'h0000_0055);
    checkOutput("s1_no_inject_valid", mvLog[start+6], 1);
    checkOutput("s1_active_src", asLog[start+6], 1);
    checkOutput("s1_word", outLog[b+3], 32'h0000_0055);
    checkOutput("s1_inject_count", inject_count, 0);

    // Round-robin 16-word bursts with one idle bubble between grants
    b = outLog.size();
    applyStimulus(2'b10, 1'b1);
    for (int i = 0; i < 40; i++) begin
      s0q.push_back(32'h0000_0100 + i);
      s1q.push_back(32'h1000_0000 + i);
    end
    start = cycleNum + 1;
    waitOut(b + 80, 200);
    checkOutput("rr_s0_first", outLog[b+0], 32'h0000_0100);
    checkOutput("rr_s0_last", outLog[b+15], 32'h0000_010F);
    checkOutput("rr_s1_first", outLog[b+16], 32'h1000_0000);
    checkOutput("rr_s1_last", outLog[b+31], 32'h1000_000F);
    checkOutput("rr_s0_resume", outLog[b+32], 32'h0000_0110);
    checkOutput("rr_final", outLog[b+79], 32'h1000_0027);
    checkOutput("rr_burst_end_valid", mvLog[start+16], 1);
    checkOutput("rr_bubble", mvLog[start+17], 0);
    checkOutput("rr_next_valid", mvLog[start+18], 1);
    checkOutput("rr_next_src", asLog[start+18], 1);
    checkOutput("rr_next_data", mdLog[start+18], 32'h1000_0000);
    checkOutput("rr_inject_count", inject_count, 0);

    // Mode 11 written during an s0 burst: burst finishes, then nothing is granted
    repeat (2) @(negedge clk);
    b = outLog.size();
    applyStimulus(2'b00, 1'b1);
    for (int i = 0; i < 20; i++) s0q.push_back(32'h3000_0000 + i);
    for (int i = 0; i < 3; i++) s1q.push_back(32'h4000_0000 + i);
    start = cycleNum + 1;
    repeat (3) @(negedge clk);
    applyStimulus(2'b11, 1'b1);
    repeat (25) @(negedge clk);
    checkOutput("off_word_count", outLog.size() - b, 16);
    checkOutput("off_last_word", outLog[b+15], 32'h3000_000F);
    checkOutput("off_burst_end", mvLog[start+16], 1);
    checkOutput("off_after_valid", mvLog[start+17], 0);
    checkOutput("off_late_valid", mvLog[start+24], 0);
    checkOutput("off_late_s0rdy", r0Log[start+24], 0);
    checkOutput("off_late_s1rdy", r1Log[start+24], 0);
    checkOutput("off_late_grant", gaLog[start+24], 0);
    checkOutput("off_s0_left", s0q.size(), 4);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
